// File: rtl/btb_array_pkg.sv
// Shared types and helpers for the BTB storage array and its controller.
package btb_array_pkg;

    // Controller states: array self-initialisation, then normal operation.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Widest word the lane-merge helper handles; one mask bit per data bit at most.
    localparam int unsigned MAX_DATA_WIDTH = 256;

    // Number of write-mask lanes in a word.
    function automatic int unsigned num_lanes(input int unsigned data_width,
                                              input int unsigned lane_width);
        return data_width / lane_width;
    endfunction

    // Per-lane merge: lanes with mask=1 take new_word, others keep old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_DATA_WIDTH-1:0] mask,
        input int unsigned               lane_width
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < MAX_DATA_WIDTH; b++) begin
            if (mask[b / lane_width]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/btb_array_mem.sv
// Plain 1W/1R storage: lane-masked write, registered read (macro-replaceable).
module btb_array_mem
    import btb_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned LANE_WIDTH = 10,
    localparam int unsigned NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH),
    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_LANES-1:0]  wmask,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] wr_word_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Next write word and next read register value; read holds when idle.
    always_comb begin
        wr_word_d = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem_q[waddr]),
                                           MAX_DATA_WIDTH'(wdata),
                                           MAX_DATA_WIDTH'(wmask),
                                           LANE_WIDTH));
        rdata_d   = re ? mem_q[raddr] : rdata_q;
    end

    // Storage write; read samples pre-write contents on a same-edge collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wr_word_d;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/btb_array_ctrl.sv
// BTB array controller: init/flush clear FSM, masked writes, write-first forwarding, read-valid.
module btb_array_ctrl
    import btb_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned LANE_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_LANES-1:0]  wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data
);

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  data_ok_q,  data_ok_d;
    logic                  fwd_hit_q,  fwd_hit_d;
    logic [NUM_LANES-1:0]  fwd_mask_q, fwd_mask_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    logic                  wr_fire_c;
    logic                  rd_fire_c;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_waddr_c;
    logic [NUM_LANES-1:0]  mem_wmask_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [NUM_LANES-1:0]  out_mask_c;

    // Port arbitration: INIT owns the write port; flush drops a user write.
    always_comb begin
        wr_fire_c   = (state_q == READY) && wr_en && !flush;
        rd_fire_c   = (state_q == READY) && rd_en;
        mem_we_c    = rst_n && ((state_q == INIT) || wr_fire_c);
        mem_waddr_c = wr_addr;
        mem_wmask_c = wr_mask;
        mem_wdata_c = wr_data;
        if (state_q == INIT) begin
            mem_waddr_c = init_ptr_q;
            mem_wmask_c = '1;
            mem_wdata_c = INIT_VALUE;
        end
    end

    // Next-state logic for the clear FSM and the read handshake.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        rd_valid_d = rd_fire_c;
        data_ok_d  = data_ok_q || rd_fire_c;
        fwd_hit_d  = fwd_hit_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;

        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + ADDR_WIDTH'(1);
                if (&init_ptr_q) begin
                    state_d = READY;
                end
                if (flush) begin
                    state_d    = INIT;
                    init_ptr_d = '0;
                end
            end
            READY: begin
                if (flush) begin
                    state_d    = INIT;
                    init_ptr_d = '0;
                end
            end
            default: begin
                state_d    = INIT;
                init_ptr_d = '0;
            end
        endcase

        // Capture forwarding info only on a read so rd_data holds between reads.
        if (rd_fire_c) begin
            fwd_hit_d  = wr_fire_c && (wr_addr == rd_addr);
            fwd_mask_d = wr_mask;
            fwd_data_d = wr_data;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            rd_valid_q <= 1'b0;
            data_ok_q  <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rd_valid_q <= rd_valid_d;
            data_ok_q  <= data_ok_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    btb_array_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (mem_waddr_c),
        .wmask (mem_wmask_c),
        .wdata (mem_wdata_c),
        .re    (rd_fire_c),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    // Output read data: forwarded lanes over stored lanes; zero until the first read after reset.
    always_comb begin
        out_mask_c = fwd_hit_q ? fwd_mask_q : '0;
        rd_data    = '0;
        if (data_ok_q) begin
            rd_data = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem_rdata),
                                             MAX_DATA_WIDTH'(fwd_data_q),
                                             MAX_DATA_WIDTH'(out_mask_c),
                                             LANE_WIDTH));
        end
    end

    assign ready    = (state_q == READY);
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_btb_array_ctrl.sv
// Self-checking bench for btb_array_ctrl: default config with a read scoreboard, plus a 32/4/8 config.
module tb_btb_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: 20-bit data, 128 entries, 2 lanes.
    logic        rst_n;
    logic        flush;
    logic        ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [1:0]  wr_mask;
    logic [19:0] wr_data;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic        rd_valid;
    logic [19:0] rd_data;

    // Alternate configuration: 32-bit data, 16 entries, 4 lanes.
    logic        b_rst_n;
    logic        b_flush;
    logic        b_ready;
    logic        b_wr_en;
    logic [3:0]  b_wr_addr;
    logic [3:0]  b_wr_mask;
    logic [31:0] b_wr_data;
    logic        b_rd_en;
    logic [3:0]  b_rd_addr;
    logic        b_rd_valid;
    logic [31:0] b_rd_data;

    btb_array_ctrl #(
        .DATA_WIDTH (20), .ADDR_WIDTH (7), .LANE_WIDTH (10), .INIT_VALUE (20'h0)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .flush (flush), .ready (ready),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_mask (wr_mask), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_valid (rd_valid), .rd_data (rd_data)
    );

    btb_array_ctrl #(
        .DATA_WIDTH (32), .ADDR_WIDTH (4), .LANE_WIDTH (8), .INIT_VALUE (32'h0)
    ) dut_b (
        .clk (clk), .rst_n (b_rst_n), .flush (b_flush), .ready (b_ready),
        .wr_en (b_wr_en), .wr_addr (b_wr_addr), .wr_mask (b_wr_mask), .wr_data (b_wr_data),
        .rd_en (b_rd_en), .rd_addr (b_rd_addr), .rd_valid (b_rd_valid), .rd_data (b_rd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned due;
        logic [19:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for dut_a: every rd_valid must match a queued read due this cycle.
    exp_t mon_e;
    logic mon_exp;
    always @(posedge clk) begin
        #1;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rd_missing: read due cycle %0d never returned, wanted data %h", mon_e.due, mon_e.data);
        end
        mon_exp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (rd_valid !== 1'b0 || mon_exp) begin
            n_checks++;
            if (rd_valid !== mon_exp) begin
                n_fail++;
                $display("FAIL rd_valid: cycle %0d got %b want %b", cyc, rd_valid, mon_exp);
                if (mon_exp) mon_e = exp_q.pop_front();
            end else begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (rd_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL rd_data: cycle %0d got %h want %h", cyc, rd_data, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [6:0] addr, input logic [19:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        exp_q.push_back('{due: cyc + 1, data: exp});
        step();
        rd_en = 1'b0;
    endtask

    task automatic issue_write(input logic [6:0] addr, input logic [19:0] data, input logic [1:0] mask);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_mask = mask;
        step();
        wr_en = 1'b0;
    endtask

    // Counts sampled cycles with ready low, bounded.
    task automatic wait_ready(output int unsigned low_cycles);
        low_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (ready === 1'b1) break;
            low_cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        int unsigned lc;
        rst_n = 1'b0;
        step(); step(); step();
        n_checks++; if (ready !== 1'b0)     begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 20'h0)  begin n_fail++; $display("FAIL reset_rd_data: got %h want 00000", rd_data); end
        rst_n = 1'b1;
        wait_ready(lc);
        n_checks++; if (lc != 128) begin n_fail++; $display("FAIL init_length: got %0d want 128", lc); end
        issue_read(7'd0, 20'h0);
        issue_read(7'd64, 20'h0);
        issue_read(7'd127, 20'h0);
        step(); step();
    endtask

    task automatic test_masked_write();
        logic [19:0] first;
        logic [19:0] second;
        first  = 20'hABCDE;
        second = 20'h12345;
        issue_write(7'd5, first, 2'b11);
        issue_read(7'd5, 20'hABCDE);
        issue_write(7'd5, second, 2'b01);
        issue_read(7'd5, {first[19:10], second[9:0]});
        step(); step();
    endtask

    task automatic test_collision();
        // Upper-lane write to addr 9 collides with a read of addr 9.
        wr_en = 1'b1; wr_addr = 7'd9; wr_data = 20'h5A5A5; wr_mask = 2'b10;
        rd_en = 1'b1; rd_addr = 7'd9;
        exp_q.push_back('{due: cyc + 1, data: 20'h5A400});
        step();
        // Write to 11 alongside a read of 10: no forwarding.
        wr_addr = 7'd11; wr_data = 20'hFFFFF; wr_mask = 2'b11;
        rd_addr = 7'd10;
        exp_q.push_back('{due: cyc + 1, data: 20'h00000});
        step();
        // Zero-mask collision is a no-op write.
        wr_addr = 7'd9; wr_data = 20'hFFFFF; wr_mask = 2'b00;
        rd_addr = 7'd9;
        exp_q.push_back('{due: cyc + 1, data: 20'h5A400});
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        issue_read(7'd9, 20'h5A400);
        issue_read(7'd11, 20'hFFFFF);
        step(); step();
    endtask

    task automatic test_flush();
        int unsigned lc;
        issue_write(7'd3, 20'hFFFFF, 2'b11);
        issue_read(7'd3, 20'hFFFFF);
        // Flush wins over the write to 4; the read of 4 sees pre-flush data unforwarded.
        flush = 1'b1;
        wr_en = 1'b1; wr_addr = 7'd4; wr_data = 20'h12345; wr_mask = 2'b11;
        rd_en = 1'b1; rd_addr = 7'd4;
        exp_q.push_back('{due: cyc + 1, data: 20'h00000});
        step();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wait_ready(lc);
        n_checks++; if (lc != 128) begin n_fail++; $display("FAIL flush_length: got %0d want 128", lc); end
        issue_read(7'd3, 20'h0);
        issue_read(7'd4, 20'h0);
        issue_write(7'd6, 20'h0F0F0, 2'b11);
        issue_read(7'd6, 20'h0F0F0);
        step(); step(); step();
        n_checks++; if (rd_data !== 20'h0F0F0) begin n_fail++; $display("FAIL rd_data_hold: got %h want 0f0f0", rd_data); end
    endtask

    task automatic test_reset_and_reinit();
        int unsigned lc;
        issue_write(7'd7, 20'h13579, 2'b11);
        issue_read(7'd7, 20'h13579);
        // Read request coinciding with reset is cancelled.
        rd_en = 1'b1; rd_addr = 7'd7; rst_n = 1'b0;
        step();
        rd_en = 1'b0;
        n_checks++; if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_cancel_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 20'h0)  begin n_fail++; $display("FAIL rst_rd_data: got %h want 00000", rd_data); end
        n_checks++; if (ready !== 1'b0)     begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
        rst_n = 1'b1;
        wait_ready(lc);
        n_checks++; if (lc != 128) begin n_fail++; $display("FAIL rst_init_length: got %0d want 128", lc); end
        // Flush at INIT cycle 60 restarts the sweep.
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (60) step();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_init_ready: got %b want 0", ready); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_ready(lc);
        n_checks++; if (lc != 128) begin n_fail++; $display("FAIL init_flush_length: got %0d want 128", lc); end
    endtask

    task automatic test_init_ignores_requests();
        int unsigned lc;
        logic        saw_valid;
        saw_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 7'd20; wr_data = 20'hFFFFF; wr_mask = 2'b11;
        rd_en = 1'b1; rd_addr = 7'd20;
        lc = 0;
        for (int i = 0; i < 400; i++) begin
            if (ready === 1'b1) break;
            if (rd_valid !== 1'b0) saw_valid = 1'b1;
            lc++;
            step();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL init_rd_valid: got %b want 0", saw_valid); end
        n_checks++; if (lc != 128) begin n_fail++; $display("FAIL init_busy_length: got %0d want 128", lc); end
        issue_read(7'd20, 20'h0);
        step(); step();
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] mask);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_mask = mask;
        step();
        b_wr_en = 1'b0;
    endtask

    task automatic b_read(input logic [3:0] addr, output logic [31:0] data, output logic valid);
        b_rd_en = 1'b1; b_rd_addr = addr;
        step();
        b_rd_en = 1'b0;
        data  = b_rd_data;
        valid = b_rd_valid;
    endtask

    task automatic test_alt_config();
        int unsigned lc;
        logic [31:0] d;
        logic        v;
        b_rst_n = 1'b0;
        step(); step();
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL b_reset_ready: got %b want 0", b_ready); end
        b_rst_n = 1'b1;
        lc = 0;
        for (int i = 0; i < 100; i++) begin
            if (b_ready === 1'b1) break;
            lc++;
            step();
        end
        n_checks++; if (lc != 16) begin n_fail++; $display("FAIL b_init_length: got %0d want 16", lc); end
        b_read(4'd15, d, v);
        n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL b_read_15: got v=%b %h want v=1 00000000", v, d); end
        b_write(4'd5, 32'hAABBCCDD, 4'b1111);
        b_read(4'd5, d, v);
        n_checks++; if (v !== 1'b1 || d !== 32'hAABBCCDD) begin n_fail++; $display("FAIL b_full_write: got v=%b %h want v=1 aabbccdd", v, d); end
        b_write(4'd5, 32'h11223344, 4'b0101);
        b_read(4'd5, d, v);
        n_checks++; if (v !== 1'b1 || d !== 32'hAA22CC44) begin n_fail++; $display("FAIL b_masked_write: got v=%b %h want v=1 aa22cc44", v, d); end
        b_wr_en = 1'b1; b_wr_addr = 4'd9; b_wr_data = 32'h5A5A5A5A; b_wr_mask = 4'b1000;
        b_rd_en = 1'b1; b_rd_addr = 4'd9;
        step();
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        n_checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h5A000000) begin n_fail++; $display("FAIL b_collision: got v=%b %h want v=1 5a000000", b_rd_valid, b_rd_data); end
        b_write(4'd3, 32'hFFFFFFFF, 4'b1111);
        b_flush = 1'b1;
        b_wr_en = 1'b1; b_wr_addr = 4'd4; b_wr_data = 32'h12345678; b_wr_mask = 4'b1111;
        step();
        b_flush = 1'b0; b_wr_en = 1'b0;
        lc = 0;
        for (int i = 0; i < 100; i++) begin
            if (b_ready === 1'b1) break;
            lc++;
            step();
        end
        n_checks++; if (lc != 16) begin n_fail++; $display("FAIL b_flush_length: got %0d want 16", lc); end
        b_read(4'd3, d, v);
        n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL b_flush_addr3: got v=%b %h want v=1 00000000", v, d); end
        b_read(4'd4, d, v);
        n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL b_flush_addr4: got v=%b %h want v=1 00000000", v, d); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_mask = '0;
        b_wr_data = '0; b_rd_en = 1'b0; b_rd_addr = '0;

        test_reset();
        test_masked_write();
        test_collision();
        test_flush();
        test_reset_and_reinit();
        test_init_ignores_requests();
        test_alt_config();

        step(); step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending reads want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
